result_serializer: RTL and testbench



---
 rtl/cmp_pkg.sv | 20 ++
 rtl/piso_reg.sv | 42 ++++
 rtl/result_serializer.sv | 177 +++++++++++++++++
 tb/tb_result_serializer.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compressor datapath serial back end.
//   N_DST_DEFAULT : result columns per compressor word
//   ser_state_t   : result serializer FSM state
//   cnt_width()   : bit-counter width able to index n positions
package cmp_pkg;

  localparam int unsigned N_DST_DEFAULT = 35;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LAST
  } ser_state_t;

  // Smallest width w with 2**w >= n, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-load, shift-right-by-one register. Bit 0 is the serial output;
// zeros enter at the top. A parallel load takes priority over a shift.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset, clears the register
//   load_en_i   capture load_data_i
//   shift_en_i  shift right by one
//   load_data_i parallel word
//   sout_o      current bit 0
module piso_reg #(
  parameter int unsigned Width = 35
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic             shift_en_i,
  input  logic [Width-1:0] load_data_i,
  output logic             sout_o
);

  logic [Width-1:0] shreg_d, shreg_q;

  always_comb begin
    shreg_d = shreg_q;
    if (load_en_i) begin
      shreg_d = load_data_i;
    end else if (shift_en_i) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout_o = shreg_q[0];

endmodule

// File: rtl/result_serializer.sv
// Result serializer: captures the 35 compressor result columns on a load
// strobe into a holding register, moves the held word into a shifter as soon
// as the shifter is free, and emits it LSB-first on a one-bit valid/ready
// stream. The holding register lets the next word wait behind the one being
// shifted, so back-to-back words leave with no bubble.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   dst0..dst34          result columns, dst{k} is word bit k
//   load / load_ack      capture request / one-cycle acceptance pulse
//   load_ready           holding register is empty
//   sout, sout_valid     serial bit and its qualifier
//   sout_ready           downstream accepts the bit
//   sout_last            final bit of a word is on sout
//   busy                 shifter or holding register occupied
module result_serializer
  import cmp_pkg::*;
#(
  parameter int unsigned N_DST = N_DST_DEFAULT,
  parameter int unsigned CNT_W = cnt_width(N_DST)
) (
  input  logic clk,
  input  logic rst,
  input  logic dst0,
  input  logic dst1,
  input  logic dst2,
  input  logic dst3,
  input  logic dst4,
  input  logic dst5,
  input  logic dst6,
  input  logic dst7,
  input  logic dst8,
  input  logic dst9,
  input  logic dst10,
  input  logic dst11,
  input  logic dst12,
  input  logic dst13,
  input  logic dst14,
  input  logic dst15,
  input  logic dst16,
  input  logic dst17,
  input  logic dst18,
  input  logic dst19,
  input  logic dst20,
  input  logic dst21,
  input  logic dst22,
  input  logic dst23,
  input  logic dst24,
  input  logic dst25,
  input  logic dst26,
  input  logic dst27,
  input  logic dst28,
  input  logic dst29,
  input  logic dst30,
  input  logic dst31,
  input  logic dst32,
  input  logic dst33,
  input  logic dst34,
  input  logic load,
  output logic load_ack,
  output logic load_ready,
  output logic sout,
  output logic sout_valid,
  input  logic sout_ready,
  output logic sout_last,
  output logic busy
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_DST - 1);

  logic [N_DST_DEFAULT-1:0] dst_all;
  logic [N_DST-1:0]         dst_word;

  ser_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [N_DST-1:0] hold_d, hold_q;
  logic             hold_full_d, hold_full_q;
  logic             load_ack_d, load_ack_q;

  logic handshake;
  logic load_accept;
  logic xfer;
  logic shreg_load;
  logic shreg_shift;

  assign dst_all = {dst34, dst33, dst32, dst31, dst30, dst29, dst28, dst27, dst26, dst25,
                    dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17, dst16, dst15,
                    dst14, dst13, dst12, dst11, dst10, dst9, dst8, dst7, dst6, dst5,
                    dst4, dst3, dst2, dst1, dst0};
  assign dst_word = dst_all[N_DST-1:0];

  assign sout_valid = (state_q != IDLE);
  assign sout_last  = (state_q == LAST);
  assign handshake  = sout_valid && sout_ready;

  // Ready comes from the pre-edge flag, so a word leaving the holding register
  // on this edge still refuses a same-cycle load.
  assign load_ready  = !hold_full_q;
  assign load_accept = load && load_ready;

  // Refill the shifter when it is empty, or in the same edge that retires the
  // final bit of the current word (this is what removes the inter-word bubble).
  assign xfer = hold_full_q && ((state_q == IDLE) || ((state_q == LAST) && handshake));

  assign busy     = (state_q != IDLE) || hold_full_q;
  assign load_ack = load_ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_ack_d  = load_accept;
    shreg_load  = 1'b0;
    shreg_shift = 1'b0;

    // load_accept needs an empty holder and xfer a full one, so they never
    // collide on the holding register.
    if (load_accept) begin
      hold_d      = dst_word;
      hold_full_d = 1'b1;
    end

    if (xfer) begin
      hold_full_d = 1'b0;
      shreg_load  = 1'b1;
      cnt_d       = '0;
      state_d     = (N_DST == 1) ? LAST : SHIFT;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (handshake) begin
            shreg_shift = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            if (cnt_d == LastIdx) begin
              state_d = LAST;
            end
          end
        end
        LAST: begin
          if (handshake) begin
            shreg_shift = 1'b1;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      load_ack_q  <= load_ack_d;
    end
  end

  piso_reg #(
    .Width (N_DST)
  ) u_piso_reg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_en_i   (shreg_load),
    .shift_en_i  (shreg_shift),
    .load_data_i (hold_q),
    .sout_o      (sout)
  );

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer. Inputs change on the falling
// edge and outputs are sampled there too. The reference model: every accepted
// word must come out as 35 beats LSB-first with sout_last on beat 34 only, in
// acceptance order; timing expectations are derived from cycle counts.
module tb_result_serializer;

  localparam int NB = 35;
  localparam logic [NB-1:0] LastPat = 35'h4_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          sout_ready;
  logic [NB-1:0] dst_w;
  logic          load_ack, load_ready, sout, sout_valid, sout_last, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit obs_bit[$];
  bit obs_last[$];
  int obs_cyc[$];

  always #5 clk = ~clk;

  result_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .dst0       (dst_w[0]),
    .dst1       (dst_w[1]),
    .dst2       (dst_w[2]),
    .dst3       (dst_w[3]),
    .dst4       (dst_w[4]),
    .dst5       (dst_w[5]),
    .dst6       (dst_w[6]),
    .dst7       (dst_w[7]),
    .dst8       (dst_w[8]),
    .dst9       (dst_w[9]),
    .dst10      (dst_w[10]),
    .dst11      (dst_w[11]),
    .dst12      (dst_w[12]),
    .dst13      (dst_w[13]),
    .dst14      (dst_w[14]),
    .dst15      (dst_w[15]),
    .dst16      (dst_w[16]),
    .dst17      (dst_w[17]),
    .dst18      (dst_w[18]),
    .dst19      (dst_w[19]),
    .dst20      (dst_w[20]),
    .dst21      (dst_w[21]),
    .dst22      (dst_w[22]),
    .dst23      (dst_w[23]),
    .dst24      (dst_w[24]),
    .dst25      (dst_w[25]),
    .dst26      (dst_w[26]),
    .dst27      (dst_w[27]),
    .dst28      (dst_w[28]),
    .dst29      (dst_w[29]),
    .dst30      (dst_w[30]),
    .dst31      (dst_w[31]),
    .dst32      (dst_w[32]),
    .dst33      (dst_w[33]),
    .dst34      (dst_w[34]),
    .load       (load),
    .load_ack   (load_ack),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  // Record the beat that the coming rising edge will accept, then advance.
  task automatic step();
    if (sout_valid && sout_ready && !rst) begin
      obs_bit.push_back(sout);
      obs_last.push_back(sout_last);
      obs_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_obs();
    obs_bit.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  // Returns the cycle at which load_ack was seen, or -1 on timeout.
  task automatic wait_ack(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (load_ack === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic run_until_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy === 1'b0 && sout_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // {last pattern, data} of the next 35 recorded beats; X if too few.
  function automatic logic [2*NB-1:0] pop_word();
    logic [NB-1:0] w;
    logic [NB-1:0] l;
    if (obs_bit.size() < NB) return {(2*NB){1'bx}};
    for (int b = 0; b < NB; b++) begin
      w[b] = obs_bit.pop_front();
      l[b] = obs_last.pop_front();
    end
    return {l, w};
  endfunction

  function automatic logic [NB-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NB-1:0];
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sout_ready = 1'b0;
    dst_w      = rand_word();
    do_reset();
    n_checks++;
    if ({sout, sout_valid, sout_last, busy, load_ack, load_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 000001",
               {sout, sout_valid, sout_last, busy, load_ack, load_ready});
    end
    sout_ready = 1'b1;
    step();
    n_checks++;
    if ({sout_valid, busy, load_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %b, expected 001", {sout_valid, busy, load_ready});
    end
  endtask

  task automatic test_single();
    int c0, a;
    bit ok;
    logic [NB-1:0] w;
    logic [2*NB-1:0] got;
    clear_obs();
    sout_ready = 1'b1;
    w          = 35'h5_5555_5555;
    dst_w      = w;
    load       = 1'b1;
    c0         = cyc;
    wait_ack(5, a);
    load  = 1'b0;
    dst_w = ~w;
    n_checks++;
    if (a !== c0 + 1) begin
      n_fail++;
      $display("FAIL single_ack_latency: ack at cycle %0d, expected %0d", a, c0 + 1);
    end
    run_until_idle(80, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b valid=%b, expected idle", busy, sout_valid);
    end
    n_checks++;
    if (obs_cyc.size() != NB || obs_cyc[0] != a + 1 || obs_cyc[NB-1] != a + NB) begin
      n_fail++;
      $display("FAIL single_timing: beats=%0d first=%0d last=%0d, expected %0d/%0d/%0d",
               obs_cyc.size(), obs_cyc[0], obs_cyc[NB-1], NB, a + 1, a + NB);
    end
    got = pop_word();
    n_checks++;
    if (got !== {LastPat, w}) begin
      n_fail++;
      $display("FAIL single_word: got data=%h last=%h, expected data=%h last=%h",
               got[NB-1:0], got[2*NB-1:NB], w, LastPat);
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] words[3];
    logic [2*NB-1:0] got;
    int a1, a2, a3;
    bit ok;
    clear_obs();
    words[0]   = 35'h7_FFFF_FFFF;
    words[1]   = 35'h0_0000_0001;
    words[2]   = rand_word();
    sout_ready = 1'b1;
    dst_w      = words[0];
    load       = 1'b1;
    wait_ack(5, a1);
    dst_w = words[1];
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_when_full: load_ready=%b, expected 0", load_ready);
    end
    wait_ack(5, a2);
    n_checks++;
    if (a2 !== a1 + 2) begin
      n_fail++;
      $display("FAIL b2b_second_ack: ack at %0d, expected %0d", a2, a1 + 2);
    end
    dst_w = words[2];
    wait_ack(80, a3);
    load = 1'b0;
    n_checks++;
    if (a3 < 0 || a3 !== obs_cyc[NB-1] + 2) begin
      n_fail++;
      $display("FAIL b2b_third_ack: ack at %0d, expected %0d", a3, obs_cyc[NB-1] + 2);
    end
    run_until_idle(200, ok);
    n_checks++;
    if (!ok || obs_cyc.size() != 3 * NB || obs_cyc[3*NB-1] - obs_cyc[0] != 3 * NB - 1) begin
      n_fail++;
      $display("FAIL b2b_contiguous: idle=%b beats=%0d span=%0d, expected 1/%0d/%0d", ok,
               obs_cyc.size(), obs_cyc[3*NB-1] - obs_cyc[0], 3 * NB, 3 * NB - 1);
    end
    for (int i = 0; i < 3; i++) begin
      got = pop_word();
      n_checks++;
      if (got !== {LastPat, words[i]}) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got data=%h last=%h, expected data=%h last=%h", i,
                 got[NB-1:0], got[2*NB-1:NB], words[i], LastPat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] w;
    logic [2:0] prev;
    logic [2*NB-1:0] got;
    logic r;
    int a;
    bit done;
    clear_obs();
    w          = 35'h4_0000_0000;
    sout_ready = 1'b0;
    dst_w      = w;
    load       = 1'b1;
    wait_ack(5, a);
    load = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sout_ready = 1'($urandom_range(1, 0));
      r          = sout_ready;
      prev       = {sout, sout_valid, sout_last};
      step();
      if (prev[1] && !r) begin
        n_checks++;
        if ({sout, sout_valid, sout_last} !== prev) begin
          n_fail++;
          $display("FAIL bp_stable: got %b, expected %b", {sout, sout_valid, sout_last}, prev);
        end
      end
      if (busy === 1'b0 && sout_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done || obs_cyc.size() != NB) begin
      n_fail++;
      $display("FAIL bp_handshakes: done=%b beats=%0d, expected 1/%0d", done, obs_cyc.size(), NB);
    end
    got = pop_word();
    n_checks++;
    if (got !== {LastPat, w}) begin
      n_fail++;
      $display("FAIL bp_word: got data=%h last=%h, expected data=%h last=%h",
               got[NB-1:0], got[2*NB-1:NB], w, LastPat);
    end
  endtask

  task automatic test_load_blocked();
    logic [NB-1:0] words[3];
    logic [2*NB-1:0] got;
    int a, lr, bad;
    bit ok;
    clear_obs();
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    sout_ready = 1'b0;
    dst_w      = words[0];
    load       = 1'b1;
    wait_ack(5, a);
    dst_w = words[1];
    wait_ack(5, a);
    dst_w = words[2];
    bad   = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (load_ack !== 1'b0 || load_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL blocked_no_ack: %0d cycles with ack or ready, expected 0", bad);
    end
    sout_ready = 1'b1;
    lr         = -1;
    a          = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (load_ready === 1'b1 && lr < 0) lr = cyc;
      if (load_ack === 1'b1) begin
        a = cyc;
        break;
      end
    end
    load = 1'b0;
    n_checks++;
    if (lr < 0 || a !== lr + 1) begin
      n_fail++;
      $display("FAIL blocked_ack_timing: ready at %0d ack at %0d, expected ack at ready+1", lr, a);
    end
    run_until_idle(200, ok);
    for (int i = 0; i < 3; i++) begin
      got = pop_word();
      n_checks++;
      if (got !== {LastPat, words[i]}) begin
        n_fail++;
        $display("FAIL blocked_word%0d: got data=%h last=%h, expected data=%h last=%h", i,
                 got[NB-1:0], got[2*NB-1:NB], words[i], LastPat);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] w;
    logic [2*NB-1:0] got;
    int a, c0, lasts;
    bit ok;
    clear_obs();
    sout_ready = 1'b1;
    dst_w      = rand_word();
    load       = 1'b1;
    wait_ack(5, a);
    dst_w = rand_word();
    wait_ack(5, a);
    load = 1'b0;
    for (int i = 0; i < 60 && obs_cyc.size() < 16; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({sout, sout_valid, sout_last, busy, load_ack, load_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, expected 000001",
               {sout, sout_valid, sout_last, busy, load_ack, load_ready});
    end
    lasts = 0;
    foreach (obs_last[i]) lasts += int'(obs_last[i]);
    n_checks++;
    if (obs_cyc.size() != 16 || lasts != 0) begin
      n_fail++;
      $display("FAIL midreset_partial: beats=%0d lasts=%0d, expected 16/0", obs_cyc.size(), lasts);
    end
    clear_obs();
    w     = rand_word();
    dst_w = w;
    load  = 1'b1;
    c0    = cyc;
    wait_ack(5, a);
    load = 1'b0;
    run_until_idle(80, ok);
    n_checks++;
    if (a !== c0 + 1 || !ok || obs_cyc.size() != NB) begin
      n_fail++;
      $display("FAIL midreset_reload: ack=%0d idle=%b beats=%0d, expected %0d/1/%0d", a, ok,
               obs_cyc.size(), c0 + 1, NB);
    end
    got = pop_word();
    n_checks++;
    if (got !== {LastPat, w}) begin
      n_fail++;
      $display("FAIL midreset_word: got data=%h last=%h, expected data=%h last=%h",
               got[NB-1:0], got[2*NB-1:NB], w, LastPat);
    end
  endtask

  task automatic test_same_edge();
    logic [NB-1:0] words[3];
    logic [2*NB-1:0] got;
    int a;
    bit ok;
    clear_obs();
    for (int i = 0; i < 3; i++) words[i] = rand_word();
    sout_ready = 1'b1;
    dst_w      = words[0];
    load       = 1'b1;
    wait_ack(5, a);
    dst_w = words[1];
    wait_ack(5, a);
    load = 1'b0;
    for (int i = 0; i < 60 && sout_last !== 1'b1; i++) step();
    dst_w = words[2];
    load  = 1'b1;
    step();
    n_checks++;
    if ({load_ack, load_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL same_edge_refused: ack/ready=%b, expected 01", {load_ack, load_ready});
    end
    step();
    load = 1'b0;
    n_checks++;
    if (load_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL same_edge_reissue: load_ack=%b, expected 1", load_ack);
    end
    run_until_idle(200, ok);
    n_checks++;
    if (!ok || obs_cyc.size() != 3 * NB || obs_cyc[3*NB-1] - obs_cyc[0] != 3 * NB - 1) begin
      n_fail++;
      $display("FAIL same_edge_stream: idle=%b beats=%0d span=%0d, expected 1/%0d/%0d", ok,
               obs_cyc.size(), obs_cyc[3*NB-1] - obs_cyc[0], 3 * NB, 3 * NB - 1);
    end
    for (int i = 0; i < 3; i++) begin
      got = pop_word();
      n_checks++;
      if (got !== {LastPat, words[i]}) begin
        n_fail++;
        $display("FAIL same_edge_word%0d: got data=%h last=%h, expected data=%h last=%h", i,
                 got[NB-1:0], got[2*NB-1:NB], words[i], LastPat);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] words[4];
    logic [NB-1:0] exp_q[$];
    logic [2*NB-1:0] got;
    int idx;
    bit done;
    clear_obs();
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    idx  = 0;
    done = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!load && idx < 4) begin
        dst_w = words[idx];
        load  = 1'b1;
      end
      sout_ready = 1'($urandom_range(1, 0));
      step();
      if (load && load_ack === 1'b1) begin
        exp_q.push_back(words[idx]);
        idx++;
        load  = 1'b0;
        dst_w = rand_word();
      end
      if (idx == 4 && !load && busy === 1'b0 && sout_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done || obs_cyc.size() != 4 * NB) begin
      n_fail++;
      $display("FAIL random_done: done=%b beats=%0d, expected 1/%0d", done, obs_cyc.size(), 4 * NB);
    end
    for (int i = 0; i < 4; i++) begin
      got = pop_word();
      n_checks++;
      if (got !== {LastPat, words[i]}) begin
        n_fail++;
        $display("FAIL random_word%0d: got data=%h last=%h, expected data=%h last=%h", i,
                 got[NB-1:0], got[2*NB-1:NB], words[i], LastPat);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected tests to finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    sout_ready = 1'b0;
    dst_w      = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_load_blocked();
    test_reset_mid();
    test_same_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
